// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128/256 round sequencer.
// Used by aes_round_ctrl (optional AES_KEYLEN_256_EN build) and its sub-blocks.
package aes_pkg;

  localparam int AES_DW     = 128;
  localparam int AES_NR128  = 10;
  localparam int AES_NR256  = 14;
  localparam int AES_KIDX_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } aes_state_e;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Plaintext, key-store, round-datapath and ciphertext signals of the AES sequencer.
// slave = the sequencer's view, master = the surrounding datapath/key store view.
interface aes_round_ctrl_if
  import aes_pkg::*;
#(
  parameter int DW     = AES_DW,
  parameter int KIDX_W = AES_KIDX_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic              key_req;
  logic [KIDX_W-1:0] key_idx;
  logic              key_valid;
  logic [DW-1:0]     round_key;
  logic [DW-1:0]     rnd_state;
  logic              rnd_final;
  logic [DW-1:0]     rnd_result;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;

  modport slave (
    input  in_valid, in_data, key_valid, round_key, rnd_result, out_ready,
    output in_ready, key_req, key_idx, rnd_state, rnd_final, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, key_valid, round_key, rnd_result, out_ready,
    input  in_ready, key_req, key_idx, rnd_state, rnd_final, out_valid, out_data
  );
endinterface

// File: rtl/aes_round_cnt.sv
// Loadable AES round counter with a latched round limit and terminal-count flags.
// is_penult lets the sequencer register rnd_final one cycle ahead.
module aes_round_cnt
  import aes_pkg::*;
#(
  parameter int KIDX_W = AES_KIDX_W,
  parameter int NR     = AES_NR128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              load,
  input  logic              inc,
  input  logic              limit_we,
  input  logic [KIDX_W-1:0] limit_in,
  output logic [KIDX_W-1:0] cnt,
  output logic              is_final,
  output logic              is_penult
);

  logic [KIDX_W-1:0] cnt_reg;
  logic [KIDX_W-1:0] limit_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg   <= '0;
      limit_reg <= KIDX_W'(NR);
    end else begin
      if (limit_we)
        limit_reg <= limit_in;
      if (clear)
        cnt_reg <= '0;
      else if (load)
        cnt_reg <= KIDX_W'(1);
      else if (inc && !is_final)
        cnt_reg <= cnt_reg + KIDX_W'(1);
    end
  end

  assign cnt       = cnt_reg;
  assign is_final  = (cnt_reg == limit_reg);
  assign is_penult = ((cnt_reg + KIDX_W'(1)) == limit_reg);

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: owns the state register, walks round keys 0..NR, drives the
// external round datapath. Define AES_KEYLEN_256_EN to add the key_len (10/14 rounds) input.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR     = AES_NR128,
  parameter int DW     = AES_DW,
  parameter int KIDX_W = AES_KIDX_W
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           flush,
`ifdef AES_KEYLEN_256_EN
  input  logic           key_len,
`endif
  output logic           busy,
  aes_round_ctrl_if.slave bus
);

  aes_state_e        fsm_reg;
  logic [DW-1:0]     blk_reg;
  logic              in_ready_reg;
  logic              key_req_reg;
  logic              rnd_final_reg;
  logic              out_valid_reg;
  logic              busy_reg;

  logic [KIDX_W-1:0] round_cnt;
  logic [KIDX_W-1:0] limit_in;
  logic              cnt_final;
  logic              cnt_penult;
  logic              accept;
  logic              abort;
  logic              cnt_clear;
  logic              cnt_load;
  logic              cnt_inc;

  assign accept    = (fsm_reg == IDLE) && bus.in_valid;
  assign abort     = (fsm_reg != IDLE) && flush;
  assign cnt_clear = abort || ((fsm_reg == DONE) && bus.out_ready);
  assign cnt_load  = (fsm_reg == INIT) && bus.key_valid && !flush;
  assign cnt_inc   = (fsm_reg == ROUND) && bus.key_valid && !flush && !cnt_final;

`ifdef AES_KEYLEN_256_EN
  assign limit_in = key_len ? KIDX_W'(AES_NR256) : KIDX_W'(AES_NR128);
`else
  assign limit_in = KIDX_W'(NR);
`endif

  // Round limit is latched at acceptance so key_len changes mid-block are ignored.
  aes_round_cnt #(
    .KIDX_W (KIDX_W),
    .NR     (NR)
  ) u_cnt (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (cnt_clear),
    .load      (cnt_load),
    .inc       (cnt_inc),
    .limit_we  (accept),
    .limit_in  (limit_in),
    .cnt       (round_cnt),
    .is_final  (cnt_final),
    .is_penult (cnt_penult)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_reg       <= IDLE;
      blk_reg       <= '0;
      in_ready_reg  <= 1'b1;
      key_req_reg   <= 1'b0;
      rnd_final_reg <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else if (abort) begin
      fsm_reg       <= IDLE;
      in_ready_reg  <= 1'b1;
      key_req_reg   <= 1'b0;
      rnd_final_reg <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (fsm_reg)
        IDLE: begin
          if (bus.in_valid) begin
            blk_reg      <= bus.in_data;
            fsm_reg      <= INIT;
            in_ready_reg <= 1'b0;
            key_req_reg  <= 1'b1;
            busy_reg     <= 1'b1;
          end
        end
        INIT: begin
          if (bus.key_valid) begin
            blk_reg       <= blk_reg ^ bus.round_key;
            fsm_reg       <= ROUND;
            // counter moves 0 -> 1, so round 1 is final only if the limit is 1
            rnd_final_reg <= cnt_penult;
          end
        end
        ROUND: begin
          if (bus.key_valid) begin
            blk_reg <= bus.rnd_result;
            if (cnt_final) begin
              fsm_reg       <= DONE;
              key_req_reg   <= 1'b0;
              rnd_final_reg <= 1'b0;
              out_valid_reg <= 1'b1;
            end else begin
              rnd_final_reg <= cnt_penult;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            fsm_reg       <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: fsm_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.key_req   = key_req_reg;
  assign bus.key_idx   = round_cnt;
  assign bus.rnd_state = blk_reg;
  assign bus.rnd_final = rnd_final_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = blk_reg;
  assign busy          = busy_reg;

endmodule

// File: tb/tb_aes_round_ctrl.sv
`timescale 1ns/1ps
module tb_aes_round_ctrl;
  import aes_pkg::*;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;
  logic busy;
`ifdef AES_KEYLEN_256_EN
  logic key_len;
`endif
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0]   sbox [0:255];
  logic [31:0]  w    [0:59];
  logic [127:0] rk   [0:15];

  aes_round_ctrl_if #(.DW(AES_DW), .KIDX_W(AES_KIDX_W)) bus ();

  aes_round_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
`ifdef AES_KEYLEN_256_EN
    .key_len (key_len),
`endif
    .busy    (busy),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input bit ok, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    int          nwords = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < nwords; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk[r] = (4*r + 3 < nwords) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[127 - 8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) t[rr + 4*c] = b[rr + 4*((c + rr) % 4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = t[i];
    return r ^ k;
  endfunction

  assign bus.round_key  = rk[bus.key_idx];
  assign bus.rnd_result = aes_round(bus.rnd_state, bus.round_key, bus.rnd_final);

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"},      busy === 1'b0,            busy,          1'b0);
    chk({tag, "_in_ready"},  bus.in_ready === 1'b1,    bus.in_ready,  1'b1);
    chk({tag, "_key_req"},   bus.key_req === 1'b0,     bus.key_req,   1'b0);
    chk({tag, "_key_idx"},   bus.key_idx === 4'd0,     bus.key_idx,   4'd0);
    chk({tag, "_rnd_final"}, bus.rnd_final === 1'b0,   bus.rnd_final, 1'b0);
    chk({tag, "_out_valid"}, bus.out_valid === 1'b0,   bus.out_valid, 1'b0);
    chk({tag, "_out_data"},  bus.out_data === 128'h0,  bus.out_data,  128'h0);
  endtask

  task automatic run_block(input logic [127:0] pt, input logic [127:0] exp, input int nr,
                           input int stall_idx, input int stall_len, input int exp_lat,
                           input int bp_len, input bit flush_acc);
    int           lat = 0;
    int           exp_idx = 0;
    int           stalled = 0;
    logic [127:0] held = '0;
`ifdef AES_KEYLEN_256_EN
    logic         kl_saved = key_len;
`endif
    @(negedge clk);
    chk("in_ready_idle", bus.in_ready === 1'b1, bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = pt;
    flush        = flush_acc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    flush        = 1'b0;
`ifdef AES_KEYLEN_256_EN
    key_len = ~key_len;
`endif
    chk("busy_after_accept", busy === 1'b1, busy, 1'b1);
    while (!bus.out_valid && lat < 100) begin
      chk("key_idx", bus.key_idx === 4'(exp_idx), bus.key_idx, 4'(exp_idx));
      chk("rnd_final", bus.rnd_final === (exp_idx == nr), bus.rnd_final, (exp_idx == nr));
      chk("key_req", bus.key_req === 1'b1, bus.key_req, 1'b1);
      if (exp_idx == stall_idx && stalled < stall_len) begin
        bus.key_valid = 1'b0;
        stalled++;
        held = bus.rnd_state;
      end else begin
        bus.key_valid = 1'b1;
      end
      @(posedge clk); #1;
      lat++;
      if (bus.key_valid) exp_idx++;
      else chk("stall_hold", bus.rnd_state === held, bus.rnd_state, held);
    end
    bus.key_valid = 1'b1;
    chk("latency", lat == exp_lat, lat, exp_lat);
    chk("out_valid", bus.out_valid === 1'b1, bus.out_valid, 1'b1);
    chk("out_data", bus.out_data === exp, bus.out_data, exp);
    chk("in_ready_done", bus.in_ready === 1'b0, bus.in_ready, 1'b0);
    for (int i = 0; i < bp_len; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", bus.out_valid === 1'b1, bus.out_valid, 1'b1);
      chk("bp_out_data", bus.out_data === exp, bus.out_data, exp);
      chk("bp_in_ready", bus.in_ready === 1'b0, bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("post_out_valid", bus.out_valid === 1'b0, bus.out_valid, 1'b0);
    chk("post_in_ready", bus.in_ready === 1'b1, bus.in_ready, 1'b1);
    chk("post_busy", busy === 1'b0, busy, 1'b0);
`ifdef AES_KEYLEN_256_EN
    key_len = kl_saved;
`endif
  endtask

  task automatic run_abort(input int at_idx, input bit use_reset);
    logic [127:0] held;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = PT;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.key_valid = 1'b1;
    for (int i = 0; i < at_idx; i++) begin
      @(posedge clk); #1;
    end
    chk("abort_key_idx", bus.key_idx === 4'(at_idx), bus.key_idx, 4'(at_idx));
    if (!use_reset) begin
      held  = bus.rnd_state;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy", busy === 1'b0, busy, 1'b0);
      chk("flush_in_ready", bus.in_ready === 1'b1, bus.in_ready, 1'b1);
      chk("flush_key_req", bus.key_req === 1'b0, bus.key_req, 1'b0);
      chk("flush_key_idx", bus.key_idx === 4'd0, bus.key_idx, 4'd0);
      chk("flush_state_kept", bus.out_data === held, bus.out_data, held);
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        chk("flush_no_out", bus.out_valid === 1'b0, bus.out_valid, 1'b0);
      end
    end else begin
      @(negedge clk); #2;
      reset_n = 1'b0;
      #1;
      check_reset_values("async_rst");
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout after 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.key_valid = 1'b1;
    bus.out_ready = 1'b0;
`ifdef AES_KEYLEN_256_EN
    key_len = 1'b0;
`endif
    build_sbox();
    expand(KEY128, 4);
    @(negedge clk);
    check_reset_values("reset");
    @(negedge clk);
    reset_n = 1'b1;

    run_block(PT, CT128, 10, -1, 0, 11, 0, 1'b0);
    $display("[TB] fips_c1 done");
    run_block(PT, CT128, 10, 4, 3, 14, 5, 1'b0);
    $display("[TB] key stall + backpressure done");
    run_abort(6, 1'b0);
    $display("[TB] flush at key_idx 6 done");
    run_block(PT, CT128, 10, -1, 0, 11, 0, 1'b1);
    $display("[TB] block after flush (flush with in_valid in IDLE) done");
    run_abort(5, 1'b1);
    $display("[TB] async reset mid-round done");
    run_block(PT, CT128, 10, -1, 0, 11, 0, 1'b0);
    $display("[TB] fips_c1 after reset done");
`ifdef AES_KEYLEN_256_EN
    key_len = 1'b1;
    expand(KEY256, 8);
    run_block(PT, CT256, 14, -1, 0, 15, 0, 1'b0);
    $display("[TB] fips_c3 aes-256 done");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
